i2c_burst_controller: RTL and testbench
=======================================

I2C_BURST_CONTROLLER -- requirements
Module: i2c_burst_controller

Interface
REQ-001 SHALL have parameter MAX_BYTES, default 4, the maximum number of bytes per transfer direction, legal range 1..15.
REQ-002 SHALL have parameter DATA_W, default 8*MAX_BYTES, the width of the write and read data words.
REQ-003 SHALL have parameter POLL_LIMIT, default 65535, the maximum number of status polls per byte before timeout.
REQ-004 Clock and reset ports:
- clk  in  1  single clock; all logic is on its rising edge.
- rst  in  1  asynchronous reset, active-high.
REQ-005 Host and status ports:
- memory_control  in  32  command word. Bit 0 START. Bit 1 READ. Bit 2 WRITE. Bit 3 SET_PRESCALE. Bit 4 WRRD (write then repeated-start read). Bits 11:5 slave address. Bits 15:12 WLEN. Bits 19:16 RLEN. Bits 31:20 unused.
- memory_data  in  DATA_W  write bytes; bits 15:0 carry the prescale value when SET_PRESCALE is set.
- rd_data  out  DATA_W  captured read bytes.
- done  out  1  one-cycle completion pulse.
- busy  out  1  high while a command is active.
- err_nack  out  1  slave did not acknowledge.
- err_len  out  1  illegal length.
- err_tmo  out  1  poll timeout.
REQ-006 Wishbone master ports to the i2c master core:
- wbm_adr_o  out  3
- wbm_dat_o  out  8
- wbm_dat_i  in  8
- wbm_we_o  out  1
- wbm_stb_o  out  1
- wbm_ack_i  in  1
- wbm_cyc_o  out  1
- Core register map: 0 = status (bit 0 busy, bit 3 missed_ack); 2 = slave address; 3 = command (bit 0 start, bit 1 read, bit 2 write, bit 4 stop); 4 = data FIFO; 6 = prescale low; 7 = prescale high.

Function
REQ-007 SHALL accept a command only in IDLE, and only on a rising edge of START (START=0 in the previous cycle); a held START SHALL NOT retrigger.
REQ-008 Command priority SHALL be SET_PRESCALE > WRRD > WRITE > READ; a START with none of these set SHALL be ignored.
REQ-009 The command word and memory_data SHALL be latched in the accept cycle; later input changes SHALL have no effect on the active command.
REQ-010 Length check: a length of 0 or greater than MAX_BYTES for any used length field SHALL skip all bus traffic, set err_len, and pulse done 1 cycle after accept.
REQ-011 Each bus access SHALL drive cyc=stb=1 with stable adr, dat and we until the cycle in which ack=1.
REQ-012 The cycle after ack, stb SHALL be 0 for at least 1 cycle; read data SHALL be sampled from wbm_dat_i in the ack cycle.
REQ-013 State machine:
- IDLE
- PRESC_LO, PRESC_HI
- SET_ADDR
- FILL (one FIFO write per byte, byte 0 = memory_data[7:0] first)
- CMD
- POLL_HI (wait for busy=1)
- POLL_LO (wait for busy=0)
- STOP
- DRAIN (one FIFO read per received byte)
- DONE
REQ-014 PRESCALE SHALL go IDLE->PRESC_LO->PRESC_HI->DONE (reg 6 = presc[7:0], then reg 7 = presc[15:8]).
REQ-015 WRITE SHALL go SET_ADDR->FILL(WLEN)->CMD(8'h05)->poll loop->STOP(8'h10)->DONE.
REQ-016 READ SHALL go SET_ADDR->CMD(8'h03)->poll loop->STOP->DRAIN(RLEN)->DONE.
REQ-017 WRRD SHALL run the WRITE sequence without STOP, then issue CMD 8'h03 (repeated start), run the poll loop for RLEN bytes, then STOP->DRAIN->DONE.
REQ-018 Poll loop:
- Each POLL_HI->POLL_LO->(busy=0) transition SHALL count one byte.
- After a counted byte short of the target, SHALL reissue the command: 8'h04 for write, 8'h02 for read.
- At the target count SHALL exit the loop.
REQ-019 A status read with missed_ack=1 in any poll state SHALL set err_nack and go to STOP, with no DRAIN.
REQ-020 Timeout: POLL_LIMIT consecutive polls in one poll state SHALL set err_tmo and go to STOP.
REQ-021 Read byte k SHALL land in rd_data[8k+7:8k]; bytes at index RLEN and above SHALL be zero.
REQ-022 rd_data SHALL be cleared on accept and held from DONE until the next accept.
REQ-023 err_nack, err_len and err_tmo SHALL clear on accept and hold until the next accept.
REQ-024 busy SHALL be 1 from the cycle after accept through the DONE cycle inclusive; done SHALL be 1 only in DONE; DONE SHALL return to IDLE after 1 cycle.
REQ-025 Byte counters SHALL be 4 bits wide and compared for equality only; they SHALL never wrap, because lengths are at most 15.

Reset
REQ-026 rst=1 SHALL immediately, regardless of clk, force: all wbm_* outputs 0, rd_data 0, done/busy/err_* 0, state IDLE, counters 0, prescale register 0.
REQ-027 Reset mid-transfer SHALL abort with no STOP issued; the first command accepted after reset release SHALL run normally.

Structure
REQ-028 A shared package i2c_pkg SHALL hold: state encodings, core register addresses (0, 2, 3, 4, 6, 7), command byte constants (8'h02, 8'h03, 8'h04, 8'h05, 8'h10), and the memory_control bit positions.
REQ-029 The single-access wishbone handshake SHALL be a sub-module i2c_wb_access with ports req, adr, wdat, we -> ack_pulse, rdat.

Verification
REQ-030 Prescale: START with SET_PRESCALE and memory_data=16'h012C -> writes reg6=8'h2C, then reg7=8'h01; done pulses; no error flags.
REQ-031 Write: WLEN=3, addr 7'h50, data 24'hC3B2A1 -> FIFO writes A1, B2, C3; CMD 8'h05; three busy pulses; STOP 8'h10; done.
REQ-032 WRRD: WLEN=1 (8'h10), RLEN=2, slave returns 8'h5A then 8'hA5 -> repeated start 8'h03; rd_data[15:0]=16'hA55A; rd_data[31:16]=0.
REQ-033 NACK: READ, model sets missed_ack on the first poll -> err_nack=1; STOP issued; no reg-4 reads; done pulses.
REQ-034 Length and retrigger: WLEN=0 -> err_len, done at accept+1, zero bus cycles; START held for 10 cycles -> exactly one command accepted.
REQ-035 Reset: rst=1 during POLL_LO -> all outputs 0 in the same cycle; next READ with RLEN=1 completes normally.

Source files
------------

// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared constants and types for the i2c burst controller
// Purpose: state encodings, i2c master core register map, core command bytes,
//          host command word bit positions and a length legality helper.
// Ports:   none (package).
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_PRESC_LO,
    ST_PRESC_HI,
    ST_SET_ADDR,
    ST_FILL,
    ST_CMD,
    ST_POLL_HI,
    ST_POLL_LO,
    ST_STOP,
    ST_DRAIN,
    ST_DONE
  } state_t;

  typedef enum logic [1:0] {
    MODE_PRESC,
    MODE_WRRD,
    MODE_WRITE,
    MODE_READ
  } mode_t;

  // Core register addresses
  localparam logic [2:0] REG_STATUS   = 3'd0;
  localparam logic [2:0] REG_ADDR     = 3'd2;
  localparam logic [2:0] REG_CMD      = 3'd3;
  localparam logic [2:0] REG_DATA     = 3'd4;
  localparam logic [2:0] REG_PRESC_LO = 3'd6;
  localparam logic [2:0] REG_PRESC_HI = 3'd7;

  // Core command bytes
  localparam logic [7:0] CMD_RD_NEXT  = 8'h02;
  localparam logic [7:0] CMD_RD_START = 8'h03;
  localparam logic [7:0] CMD_WR_NEXT  = 8'h04;
  localparam logic [7:0] CMD_WR_START = 8'h05;
  localparam logic [7:0] CMD_STOP     = 8'h10;

  // Core status bits
  localparam int STS_BUSY = 0;
  localparam int STS_NACK = 3;

  // Host command word bit positions
  localparam int MC_START     = 0;
  localparam int MC_READ      = 1;
  localparam int MC_WRITE     = 2;
  localparam int MC_SET_PRESC = 3;
  localparam int MC_WRRD      = 4;
  localparam int MC_ADDR_LSB  = 5;
  localparam int MC_WLEN_LSB  = 12;
  localparam int MC_RLEN_LSB  = 16;

  function automatic logic len_ok(input logic [3:0] len, input int max_bytes);
    return (len != 4'd0) && (int'(len) <= max_bytes);
  endfunction

endpackage

// File: rtl/i2c_wb_access.sv
// rtl/i2c_wb_access.sv - single wishbone access engine toward the i2c master core
// Purpose: turns a level request into one classic wishbone cycle, holds
//          adr/dat/we stable until ack, then reports a one-cycle ack_pulse
//          with the read data captured in the ack cycle.
// Ports:   clk, rst            clock, async active-high reset
//          req, adr, wdat, we  access request and its parameters
//          ack_pulse, rdat     completion pulse (cycle after ack) and read data
//          wbm_*               wishbone master signals
module i2c_wb_access (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic [2:0] adr,
  input  logic [7:0] wdat,
  input  logic       we,
  output logic       ack_pulse,
  output logic [7:0] rdat,
  output logic [2:0] wbm_adr_o,
  output logic [7:0] wbm_dat_o,
  input  logic [7:0] wbm_dat_i,
  output logic       wbm_we_o,
  output logic       wbm_stb_o,
  input  logic       wbm_ack_i,
  output logic       wbm_cyc_o
);

  logic [2:0] r_adr;
  logic [7:0] r_dat;
  logic       r_we;
  logic       r_stb;
  logic       r_ack_pulse;
  logic [7:0] r_rdat;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_adr       <= 3'd0;
      r_dat       <= 8'd0;
      r_we        <= 1'b0;
      r_stb       <= 1'b0;
      r_ack_pulse <= 1'b0;
      r_rdat      <= 8'd0;
    end else begin
      r_ack_pulse <= 1'b0;
      if (r_stb) begin
        if (wbm_ack_i) begin
          r_stb       <= 1'b0;
          r_adr       <= 3'd0;
          r_dat       <= 8'd0;
          r_we        <= 1'b0;
          r_ack_pulse <= 1'b1;
          r_rdat      <= wbm_dat_i;
        end
      end else if (req && !r_ack_pulse) begin
        // During the ack_pulse cycle the requester has not yet advanced its
        // state, so its req still refers to the finished access; ignore it.
        r_stb <= 1'b1;
        r_adr <= adr;
        r_dat <= wdat;
        r_we  <= we;
      end
    end
  end

  assign wbm_adr_o = r_adr;
  assign wbm_dat_o = r_dat;
  assign wbm_we_o  = r_we;
  assign wbm_stb_o = r_stb;
  assign wbm_cyc_o = r_stb;
  assign ack_pulse = r_ack_pulse;
  assign rdat      = r_rdat;

endmodule

// File: rtl/i2c_burst_controller.sv
// rtl/i2c_burst_controller.sv - host-commanded burst sequencer for an i2c master core
// Purpose: accepts a command word (prescale, write, read, write-then-read),
//          sequences the core registers over wishbone, polls core status per
//          byte, and returns read bytes plus error flags.
// Ports:   clk, rst                     clock, async active-high reset
//          memory_control, memory_data  command word and write bytes / prescale
//          rd_data, done, busy          read bytes, completion pulse, activity
//          err_nack, err_len, err_tmo   sticky error flags for the last command
//          wbm_*                        wishbone master toward the core
module i2c_burst_controller
  import i2c_pkg::*;
#(
  parameter int MAX_BYTES  = 4,
  parameter int DATA_W     = 8 * MAX_BYTES,
  parameter int POLL_LIMIT = 65535
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       memory_control,
  input  logic [DATA_W-1:0] memory_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              done,
  output logic              busy,
  output logic              err_nack,
  output logic              err_len,
  output logic              err_tmo,
  output logic [2:0]        wbm_adr_o,
  output logic [7:0]        wbm_dat_o,
  input  logic [7:0]        wbm_dat_i,
  output logic              wbm_we_o,
  output logic              wbm_stb_o,
  input  logic              wbm_ack_i,
  output logic              wbm_cyc_o
);

  localparam int PCW = (POLL_LIMIT > 1) ? $clog2(POLL_LIMIT + 1) : 1;

  state_t            r_state;
  mode_t             r_mode;
  logic              r_start_q;
  logic [6:0]        r_addr;
  logic [3:0]        r_wlen;
  logic [3:0]        r_rlen;
  logic [DATA_W-1:0] r_wdata;
  logic [15:0]       r_presc;
  logic [3:0]        r_cnt;
  logic [PCW-1:0]    r_poll;
  logic              r_first;
  logic              r_rd_phase;
  logic [DATA_W-1:0] r_rd_data;
  logic              r_err_nack;
  logic              r_err_len;
  logic              r_err_tmo;

  logic              w_req;
  logic [2:0]        w_adr;
  logic [7:0]        w_wdat;
  logic              w_we;
  logic              w_ack;
  logic [7:0]        w_rdat;
  logic [7:0]        w_fill_byte;
  logic              w_accept;
  logic              w_len_bad;
  mode_t             w_mode_in;
  logic [3:0]        w_wlen_in;
  logic [3:0]        w_rlen_in;
  logic [15:0]       w_presc_in;
  logic [3:0]        w_cnt_inc;
  logic [3:0]        w_target;
  logic [PCW-1:0]    w_poll_inc;
  logic              w_poll_expired;
  logic              w_sts_busy;
  logic              w_sts_nack;
  logic              w_unused_ctrl;

  assign w_unused_ctrl = &{1'b0, memory_control[31:20]};

  assign w_wlen_in  = memory_control[MC_WLEN_LSB +: 4];
  assign w_rlen_in  = memory_control[MC_RLEN_LSB +: 4];
  assign w_presc_in = 16'(memory_data);

  // Highest-priority operation wins when several bits are set together.
  always_comb begin
    w_mode_in = MODE_READ;
    if (memory_control[MC_SET_PRESC])  w_mode_in = MODE_PRESC;
    else if (memory_control[MC_WRRD])  w_mode_in = MODE_WRRD;
    else if (memory_control[MC_WRITE]) w_mode_in = MODE_WRITE;
  end

  always_comb begin
    w_len_bad = 1'b0;
    case (w_mode_in)
      MODE_WRRD:  w_len_bad = !len_ok(w_wlen_in, MAX_BYTES) || !len_ok(w_rlen_in, MAX_BYTES);
      MODE_WRITE: w_len_bad = !len_ok(w_wlen_in, MAX_BYTES);
      MODE_READ:  w_len_bad = !len_ok(w_rlen_in, MAX_BYTES);
      default:    w_len_bad = 1'b0;
    endcase
  end

  assign w_accept = (r_state == ST_IDLE) && memory_control[MC_START] && !r_start_q &&
                    (|memory_control[MC_WRRD:MC_READ]);

  assign w_cnt_inc      = r_cnt + 4'd1;
  assign w_target       = r_rd_phase ? r_rlen : r_wlen;
  assign w_poll_inc     = r_poll + 1'b1;
  assign w_poll_expired = (w_poll_inc == PCW'(POLL_LIMIT));
  assign w_sts_busy     = w_rdat[STS_BUSY];
  assign w_sts_nack     = w_rdat[STS_NACK];
  assign w_fill_byte    = r_wdata[int'(r_cnt) * 8 +: 8];

  // Bus access parameters are a pure decode of the current state.
  always_comb begin
    w_req  = 1'b0;
    w_adr  = REG_STATUS;
    w_wdat = 8'h00;
    w_we   = 1'b0;
    case (r_state)
      ST_PRESC_LO: begin w_req = 1'b1; w_adr = REG_PRESC_LO; w_wdat = r_presc[7:0];  w_we = 1'b1; end
      ST_PRESC_HI: begin w_req = 1'b1; w_adr = REG_PRESC_HI; w_wdat = r_presc[15:8]; w_we = 1'b1; end
      ST_SET_ADDR: begin w_req = 1'b1; w_adr = REG_ADDR;     w_wdat = {1'b0, r_addr}; w_we = 1'b1; end
      ST_FILL:     begin w_req = 1'b1; w_adr = REG_DATA;     w_wdat = w_fill_byte;   w_we = 1'b1; end
      ST_CMD: begin
        w_req = 1'b1;
        w_adr = REG_CMD;
        w_we  = 1'b1;
        if (r_rd_phase) w_wdat = r_first ? CMD_RD_START : CMD_RD_NEXT;
        else            w_wdat = r_first ? CMD_WR_START : CMD_WR_NEXT;
      end
      ST_POLL_HI,
      ST_POLL_LO:  begin w_req = 1'b1; w_adr = REG_STATUS; end
      ST_STOP:     begin w_req = 1'b1; w_adr = REG_CMD;  w_wdat = CMD_STOP; w_we = 1'b1; end
      ST_DRAIN:    begin w_req = 1'b1; w_adr = REG_DATA; end
      default:     w_req = 1'b0;
    endcase
  end

  i2c_wb_access u_wb (
    .clk       (clk),
    .rst       (rst),
    .req       (w_req),
    .adr       (w_adr),
    .wdat      (w_wdat),
    .we        (w_we),
    .ack_pulse (w_ack),
    .rdat      (w_rdat),
    .wbm_adr_o (wbm_adr_o),
    .wbm_dat_o (wbm_dat_o),
    .wbm_dat_i (wbm_dat_i),
    .wbm_we_o  (wbm_we_o),
    .wbm_stb_o (wbm_stb_o),
    .wbm_ack_i (wbm_ack_i),
    .wbm_cyc_o (wbm_cyc_o)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_mode     <= MODE_PRESC;
      r_start_q  <= 1'b0;
      r_addr     <= 7'd0;
      r_wlen     <= 4'd0;
      r_rlen     <= 4'd0;
      r_wdata    <= '0;
      r_presc    <= 16'd0;
      r_cnt      <= 4'd0;
      r_poll     <= '0;
      r_first    <= 1'b0;
      r_rd_phase <= 1'b0;
      r_rd_data  <= '0;
      r_err_nack <= 1'b0;
      r_err_len  <= 1'b0;
      r_err_tmo  <= 1'b0;
    end else begin
      r_start_q <= memory_control[MC_START];
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_mode     <= w_mode_in;
            r_addr     <= memory_control[MC_ADDR_LSB +: 7];
            r_wlen     <= w_wlen_in;
            r_rlen     <= w_rlen_in;
            r_wdata    <= memory_data;
            r_cnt      <= 4'd0;
            r_poll     <= '0;
            r_first    <= 1'b1;
            r_rd_phase <= (w_mode_in == MODE_READ);
            r_rd_data  <= '0;
            r_err_nack <= 1'b0;
            r_err_tmo  <= 1'b0;
            r_err_len  <= w_len_bad;
            if (w_len_bad) begin
              r_state <= ST_DONE;
            end else if (w_mode_in == MODE_PRESC) begin
              r_presc <= w_presc_in;
              r_state <= ST_PRESC_LO;
            end else begin
              r_state <= ST_SET_ADDR;
            end
          end
        end
        ST_PRESC_LO: if (w_ack) r_state <= ST_PRESC_HI;
        ST_PRESC_HI: if (w_ack) r_state <= ST_DONE;
        ST_SET_ADDR: if (w_ack) r_state <= (r_mode == MODE_READ) ? ST_CMD : ST_FILL;
        ST_FILL: begin
          if (w_ack) begin
            if (w_cnt_inc == r_wlen) begin
              r_cnt   <= 4'd0;
              r_state <= ST_CMD;
            end else begin
              r_cnt <= w_cnt_inc;
            end
          end
        end
        ST_CMD: begin
          if (w_ack) begin
            r_poll  <= '0;
            r_state <= ST_POLL_HI;
          end
        end
        ST_POLL_HI: begin
          if (w_ack) begin
            if (w_sts_nack) begin
              r_err_nack <= 1'b1;
              r_state    <= ST_STOP;
            end else if (w_sts_busy) begin
              r_poll  <= '0;
              r_state <= ST_POLL_LO;
            end else if (w_poll_expired) begin
              r_err_tmo <= 1'b1;
              r_state   <= ST_STOP;
            end else begin
              r_poll <= w_poll_inc;
            end
          end
        end
        ST_POLL_LO: begin
          if (w_ack) begin
            if (w_sts_nack) begin
              r_err_nack <= 1'b1;
              r_state    <= ST_STOP;
            end else if (!w_sts_busy) begin
              if (w_cnt_inc == w_target) begin
                r_cnt <= 4'd0;
                if (!r_rd_phase && (r_mode == MODE_WRRD)) begin
                  // Write phase complete: repeated start into the read phase.
                  r_rd_phase <= 1'b1;
                  r_first    <= 1'b1;
                  r_state    <= ST_CMD;
                end else begin
                  r_state <= ST_STOP;
                end
              end else begin
                r_cnt   <= w_cnt_inc;
                r_first <= 1'b0;
                r_state <= ST_CMD;
              end
            end else if (w_poll_expired) begin
              r_err_tmo <= 1'b1;
              r_state   <= ST_STOP;
            end else begin
              r_poll <= w_poll_inc;
            end
          end
        end
        ST_STOP: begin
          if (w_ack) begin
            // Only a cleanly completed read phase has bytes worth draining.
            r_state <= (r_rd_phase && !r_err_nack && !r_err_tmo) ? ST_DRAIN : ST_DONE;
          end
        end
        ST_DRAIN: begin
          if (w_ack) begin
            r_rd_data[int'(r_cnt) * 8 +: 8] <= w_rdat;
            if (w_cnt_inc == r_rlen) r_state <= ST_DONE;
            else                     r_cnt   <= w_cnt_inc;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy     = (r_state != ST_IDLE);
  assign done     = (r_state == ST_DONE);
  assign rd_data  = r_rd_data;
  assign err_nack = r_err_nack;
  assign err_len  = r_err_len;
  assign err_tmo  = r_err_tmo;

endmodule

// File: tb/tb_i2c_burst_controller.sv
// tb/tb_i2c_burst_controller.sv - scoreboard bench for i2c_burst_controller
module tb_i2c_burst_controller;

  localparam int DW = 32;
  localparam int PL = 20;

  localparam logic [4:0] OP_START = 5'h01;
  localparam logic [4:0] OP_READ  = 5'h02;
  localparam logic [4:0] OP_WRITE = 5'h04;
  localparam logic [4:0] OP_SETP  = 5'h08;
  localparam logic [4:0] OP_WRRD  = 5'h10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [31:0]   memory_control = '0;
  logic [DW-1:0] memory_data = '0;
  logic [DW-1:0] rd_data;
  logic          done, busy, err_nack, err_len, err_tmo;
  logic [2:0]    wbm_adr_o;
  logic [7:0]    wbm_dat_o;
  logic [7:0]    wbm_dat_i = 8'h00;
  logic          wbm_we_o, wbm_stb_o, wbm_cyc_o;
  logic          wbm_ack_i = 1'b0;

  always #5 clk = ~clk;

  i2c_burst_controller #(.MAX_BYTES(4), .DATA_W(DW), .POLL_LIMIT(PL)) dut (
    .clk(clk), .rst(rst),
    .memory_control(memory_control), .memory_data(memory_data),
    .rd_data(rd_data), .done(done), .busy(busy),
    .err_nack(err_nack), .err_len(err_len), .err_tmo(err_tmo),
    .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_dat_i(wbm_dat_i),
    .wbm_we_o(wbm_we_o), .wbm_stb_o(wbm_stb_o), .wbm_ack_i(wbm_ack_i),
    .wbm_cyc_o(wbm_cyc_o)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Scoreboard of expected bus writes, {adr, dat}
  logic [10:0] exp_q[$];

  // Core model state
  int         n_bus = 0;
  int         n_rd4 = 0;
  int         n_cmd = 0;
  int         sts_busy = 0;
  int         busy_left = 0;
  int         lat = 0;
  int         rx_idx = 0;
  logic [7:0] rx [0:3];
  bit         nack_mode = 0;
  bit         hang_mode = 0;
  bit         hold_busy = 0;

  always @(negedge clk) begin
    if (rst) begin
      wbm_ack_i = 1'b0;
      busy_left = 0;
      lat = 0;
    end else if (wbm_ack_i) begin
      wbm_ack_i = 1'b0;
    end else if (wbm_cyc_o && wbm_stb_o) begin
      if (lat > 0) begin
        lat--;
      end else begin
        lat = $urandom_range(0, 2);
        n_bus++;
        wbm_ack_i = 1'b1;
        if (wbm_we_o) begin
          if (exp_q.size() == 0) check("wr_unexpected", {1'b1, wbm_adr_o, wbm_dat_o}, 64'h0);
          else                   check("wr", {wbm_adr_o, wbm_dat_o}, exp_q.pop_front());
          if (wbm_adr_o == 3'd3 && (wbm_dat_o & 8'h07) != 8'h00) begin
            n_cmd++;
            busy_left = hang_mode ? 0 : (hold_busy ? 100000 : $urandom_range(1, 3));
          end
        end else if (wbm_adr_o == 3'd0) begin
          wbm_dat_i = {4'b0, nack_mode, 2'b00, busy_left > 0};
          if (busy_left > 0) begin
            busy_left--;
            sts_busy++;
          end
        end else if (wbm_adr_o == 3'd4) begin
          wbm_dat_i = (rx_idx < 4) ? rx[rx_idx] : 8'hEE;
          rx_idx++;
          n_rd4++;
        end else begin
          wbm_dat_i = 8'hEE;
        end
      end
    end
  end

  function automatic logic [31:0] mk(input logic [4:0] ops, input logic [6:0] addr,
                                     input logic [3:0] wl, input logic [3:0] rl);
    return {12'h000, rl, wl, addr, ops};
  endfunction

  task automatic push(input logic [2:0] adr, input logic [7:0] dat);
    exp_q.push_back({adr, dat});
  endtask

  task automatic issue(input logic [31:0] ctrl, input logic [DW-1:0] data);
    @(negedge clk);
    memory_control = ctrl;
    memory_data = data;
    @(negedge clk);
    memory_control = $urandom & 32'hFFFF_FFFE;
    memory_data = $urandom;
  endtask

  task automatic wait_done(input string tag, input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      if (done) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) check({tag, "_done_seen"}, done, 1);
  endtask

  task automatic run_cmd(input string tag, input logic [31:0] ctrl, input logic [DW-1:0] data,
                         input logic [DW-1:0] exp_rd, input logic [2:0] exp_err, input int exp_rd4);
    int rd4_0;
    bit ok;
    rd4_0 = n_rd4;
    issue(ctrl, data);
    wait_done(tag, 800, ok);
    if (ok) begin
      check({tag, "_err"}, {err_nack, err_len, err_tmo}, exp_err);
      check({tag, "_rd"}, rd_data, exp_rd);
      check({tag, "_busy"}, busy, 1);
      check({tag, "_q_left"}, exp_q.size(), 0);
      check({tag, "_rd4"}, n_rd4 - rd4_0, exp_rd4);
      @(negedge clk);
      check({tag, "_done_1cyc"}, {done, busy}, 2'b00);
      check({tag, "_rd_hold"}, rd_data, exp_rd);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: run did not finish, %0d/%0d", n_pass, n_chk);
    $fatal(1);
  end

  initial begin
    int cnt0;
    int n_done;
    bit ok;

    rx[0] = 8'h00; rx[1] = 8'h00; rx[2] = 8'h00; rx[3] = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_outs", {wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o,
                       done, busy, err_nack, err_len, err_tmo}, 0);
    check("rst_rd", rd_data, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Prescale wins over a simultaneous WRITE with an illegal length
    push(3'd6, 8'h2C); push(3'd7, 8'h01);
    run_cmd("presc", mk(OP_START | OP_SETP | OP_WRITE, 7'h00, 4'd0, 4'd0), 32'h0000_012C, 32'h0, 3'b000, 0);

    // Write 3 bytes; READ bit with RLEN=0 is outranked and unchecked
    cnt0 = n_cmd;
    push(3'd2, 8'h50); push(3'd4, 8'hA1); push(3'd4, 8'hB2); push(3'd4, 8'hC3);
    push(3'd3, 8'h05); push(3'd3, 8'h04); push(3'd3, 8'h04); push(3'd3, 8'h10);
    run_cmd("write", mk(OP_START | OP_WRITE | OP_READ, 7'h50, 4'd3, 4'd0), 32'hDDC3_B2A1, 32'h0, 3'b000, 0);
    check("write_busy_pulses", n_cmd - cnt0, 3);

    // Write 1 byte then repeated-start read of 2 bytes
    rx[0] = 8'h5A; rx[1] = 8'hA5; rx_idx = 0;
    push(3'd2, 8'h50); push(3'd4, 8'h10); push(3'd3, 8'h05);
    push(3'd3, 8'h03); push(3'd3, 8'h02); push(3'd3, 8'h10);
    run_cmd("wrrd", mk(OP_START | OP_WRRD | OP_WRITE, 7'h50, 4'd1, 4'd2), 32'hFFFF_FF10, 32'h0000_A55A, 3'b000, 2);

    // NACK on first poll: STOP, no drain, rd_data cleared from last command
    nack_mode = 1; rx_idx = 0;
    push(3'd2, 8'h21); push(3'd3, 8'h03); push(3'd3, 8'h10);
    run_cmd("nack", mk(OP_START | OP_READ, 7'h21, 4'd0, 4'd2), 32'h0, 32'h0, 3'b100, 0);
    nack_mode = 0;

    // WLEN=0: done exactly one cycle after accept, no bus traffic
    cnt0 = n_bus;
    @(negedge clk);
    memory_control = mk(OP_START | OP_WRITE, 7'h11, 4'd0, 4'd3);
    @(negedge clk);
    memory_control = 32'h0;
    check("len0_done_t1", {done, busy}, 2'b11);
    check("len0_err", {err_nack, err_len, err_tmo}, 3'b010);
    repeat (4) @(negedge clk);
    check("len0_bus", n_bus - cnt0, 0);

    // RLEN above MAX_BYTES
    run_cmd("len5", mk(OP_START | OP_READ, 7'h11, 4'd0, 4'd5), 32'h0, 32'h0, 3'b010, 0);

    // Held START accepts exactly once
    n_done = 0;
    @(negedge clk);
    memory_control = mk(OP_START | OP_WRITE, 7'h11, 4'd0, 4'd0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    memory_control = 32'h0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check("retrig_count", n_done, 1);

    // Core never goes busy: timeout in POLL_HI, STOP still issued
    hang_mode = 1;
    push(3'd2, 8'h33); push(3'd4, 8'h77); push(3'd3, 8'h05); push(3'd3, 8'h10);
    run_cmd("tmo", mk(OP_START | OP_WRITE, 7'h33, 4'd1, 4'd0), 32'h0000_0077, 32'h0, 3'b001, 0);
    hang_mode = 0;

    // Reset while parked in POLL_LO
    hold_busy = 1;
    cnt0 = sts_busy;
    push(3'd2, 8'h44); push(3'd3, 8'h03);
    issue(mk(OP_START | OP_READ, 7'h44, 4'd0, 4'd1), 32'h0);
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      if (sts_busy - cnt0 >= 2) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    check("rstmid_reached_poll_lo", {ok, busy}, 2'b11);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("rstmid_outs", {wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o,
                          done, busy, err_nack, err_len, err_tmo}, 0);
    check("rstmid_rd", rd_data, 0);
    exp_q.delete();
    hold_busy = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rx[0] = 8'h3C; rx_idx = 0;
    push(3'd2, 8'h44); push(3'd3, 8'h03); push(3'd3, 8'h10);
    run_cmd("after_rst", mk(OP_START | OP_READ, 7'h44, 4'd0, 4'd1), 32'h0, 32'h0000_003C, 3'b000, 1);

    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
